// File: rtl/updi_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// updi_mem_access_ctrl
//
// Sequences single-byte UPDI data-space accesses. A write is issued as STS and
// a read as LDS. The block accepts one request at a time, drives the
// instruction, payload and tx/rx control ports of updi_interface, sinks its rx
// FIFO output port, and returns one response strobe with a status code for
// every accepted request.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write                 1 = STS (write), 0 = LDS (read)
//   req_addr, req_wdata       16-bit data-space address, write byte
//   rsp_valid                 one-cycle response strobe
//   rsp_rdata                 read byte (0 for writes and for any error)
//   rsp_status                00 ok, 01 ack error, 10 rx timeout/short,
//                             11 watchdog
//   instr_converter_en, instruction, size_a, size_b, ptr, size_c, cs_addr, sib
//                             instruction fields towards updi_interface
//   data, data_len, wait_ack_after
//                             tx payload buffer, its length, ACK-wait mask
//   tx_start / tx_ready, tx_done
//                             transmit request level and its handshake/done
//   rx_n_bytes, rx_start / rx_ready, rx_done, rx_timeout, ack_error
//                             receive request and completion/status inputs
//   rx_data, rx_wr_en, rx_full
//                             rx FIFO port of updi_interface (never full here)
// -----------------------------------------------------------------------------
module updi_mem_access_ctrl #(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int WATCHDOG_CLKS  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [15:0]               req_addr,
    input  logic [7:0]                req_wdata,

    output logic                      rsp_valid,
    output logic [7:0]                rsp_rdata,
    output logic [1:0]                rsp_status,

    output logic                      instr_converter_en,
    output logic [2:0]                instruction,
    output logic [1:0]                size_a,
    output logic [1:0]                size_b,
    output logic [1:0]                ptr,
    output logic [1:0]                size_c,
    output logic [3:0]                cs_addr,
    output logic                      sib,

    output logic [7:0]                data [MAX_DATA_SIZE],
    output logic [DATA_ADDR_BITS:0]   data_len,
    output logic [MAX_DATA_SIZE-1:0]  wait_ack_after,

    output logic                      tx_start,
    input  logic                      tx_ready,
    input  logic                      tx_done,

    output logic [DATA_ADDR_BITS-1:0] rx_n_bytes,
    output logic                      rx_start,
    input  logic                      rx_ready,
    input  logic                      rx_done,
    input  logic                      rx_timeout,
    input  logic                      ack_error,

    input  logic [7:0]                rx_data,
    input  logic                      rx_wr_en,
    output logic                      rx_full
);

    // UPDI opcode field values understood by updi_interface.
    localparam logic [2:0] OP_LDS = 3'b000;
    localparam logic [2:0] OP_STS = 3'b010;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ACK_ERR = 2'b01;
    localparam logic [1:0] ST_RX_ERR  = 2'b10;
    localparam logic [1:0] ST_WDOG    = 2'b11;

    localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CLKS - 1);

    // Address bytes are followed by the data byte on STS; the interface must
    // wait for an ACK after the address phase and after the data byte.
    localparam logic [MAX_DATA_SIZE-1:0] WRITE_ACK_MASK =
        {{(MAX_DATA_SIZE-3){1'b0}}, 3'b110};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TX_START,
        TX_WAIT,
        RX_START,
        RX_WAIT,
        RESP
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        is_write_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_reg;
    logic        ack_err_reg;
    logic        got_byte_reg;
    logic [7:0]  rbyte_reg;
    logic [15:0] wd_count_reg;
    logic [7:0]  pay0_reg;
    logic [7:0]  pay1_reg;
    logic [7:0]  pay2_reg;

    // In IDLE the request bus itself is used, so the instruction and payload
    // outputs are already valid in the LOAD cycle that follows acceptance.
    logic        write_sel;
    logic [15:0] addr_sel;
    logic [7:0]  wdata_sel;

    logic        ack_err_next;
    logic        got_byte_next;
    logic [7:0]  rbyte_next;
    logic [1:0]  status_next;
    logic [7:0]  rdata_next;
    logic        wd_expired;
    logic        wd_counting;
    logic        cmd_active_next;

    assign write_sel = (state_reg == IDLE) ? req_write : is_write_reg;
    assign addr_sel  = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign wdata_sel = (state_reg == IDLE) ? req_wdata : wdata_reg;

    assign wd_expired  = (wd_count_reg == WD_LAST);
    assign wd_counting = (state_reg == TX_START) || (state_reg == TX_WAIT) ||
                         (state_reg == RX_START) || (state_reg == RX_WAIT);

    assign cmd_active_next = (state_next == LOAD)     || (state_next == TX_START) ||
                             (state_next == TX_WAIT)  || (state_next == RX_START) ||
                             (state_next == RX_WAIT);

    // Fixed instruction fields: 16-bit address, byte data, direct addressing.
    assign size_b  = 2'b00;
    assign ptr     = 2'b00;
    assign size_c  = 2'b00;
    assign cs_addr = 4'h0;
    assign sib     = 1'b0;
    assign rx_full = 1'b0;

    always_comb begin
        for (int i = 0; i < MAX_DATA_SIZE; i++) begin
            data[i] = 8'h00;
        end
        data[0] = pay0_reg;
        data[1] = pay1_reg;
        data[2] = pay2_reg;
    end

    // Next-state and response decode. status_next/rdata_next are non-zero
    // only on the transition into RESP, so the registered response fields
    // read as zero in every other cycle.
    always_comb begin
        state_next    = state_reg;
        ack_err_next  = ack_err_reg;
        got_byte_next = got_byte_reg;
        rbyte_next    = rbyte_reg;
        status_next   = ST_OK;
        rdata_next    = 8'h00;

        case (state_reg)
            IDLE: begin
                ack_err_next  = 1'b0;
                got_byte_next = 1'b0;
                rbyte_next    = 8'h00;
                if (req_valid) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                state_next = TX_START;
            end

            TX_START: begin
                if (wd_expired) begin
                    state_next  = RESP;
                    status_next = ST_WDOG;
                end else if (tx_ready) begin
                    state_next = TX_WAIT;
                end
            end

            TX_WAIT: begin
                // An ACK error in the same cycle as tx_done still counts.
                ack_err_next = ack_err_reg | ack_error;
                if (wd_expired) begin
                    state_next  = RESP;
                    status_next = ST_WDOG;
                end else if (tx_done) begin
                    if (ack_err_next) begin
                        state_next  = RESP;
                        status_next = ST_ACK_ERR;
                    end else if (is_write_reg) begin
                        state_next  = RESP;
                        status_next = ST_OK;
                    end else begin
                        state_next = RX_START;
                    end
                end
            end

            RX_START: begin
                if (wd_expired) begin
                    state_next  = RESP;
                    status_next = ST_WDOG;
                end else if (rx_ready) begin
                    state_next = RX_WAIT;
                end
            end

            RX_WAIT: begin
                // Only the first byte is kept; a byte alongside rx_done counts.
                if (rx_wr_en && !got_byte_reg) begin
                    got_byte_next = 1'b1;
                    rbyte_next    = rx_data;
                end
                if (wd_expired) begin
                    state_next  = RESP;
                    status_next = ST_WDOG;
                end else if (rx_timeout) begin
                    state_next  = RESP;
                    status_next = ST_RX_ERR;
                end else if (rx_done) begin
                    state_next = RESP;
                    if (got_byte_next) begin
                        status_next = ST_OK;
                        rdata_next  = rbyte_next;
                    end else begin
                        status_next = ST_RX_ERR;
                    end
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs are registered from the next state so they change in step
    // with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            is_write_reg       <= 1'b0;
            addr_reg           <= 16'h0000;
            wdata_reg          <= 8'h00;
            ack_err_reg        <= 1'b0;
            got_byte_reg       <= 1'b0;
            rbyte_reg          <= 8'h00;
            wd_count_reg       <= 16'h0000;
            req_ready          <= 1'b1;
            rsp_valid          <= 1'b0;
            rsp_status         <= 2'b00;
            rsp_rdata          <= 8'h00;
            instr_converter_en <= 1'b0;
            instruction        <= 3'b000;
            size_a             <= 2'b00;
            pay0_reg           <= 8'h00;
            pay1_reg           <= 8'h00;
            pay2_reg           <= 8'h00;
            data_len           <= '0;
            wait_ack_after     <= '0;
            tx_start           <= 1'b0;
            rx_start           <= 1'b0;
            rx_n_bytes         <= '0;
        end else begin
            state_reg    <= state_next;
            is_write_reg <= write_sel;
            addr_reg     <= addr_sel;
            wdata_reg    <= wdata_sel;
            ack_err_reg  <= ack_err_next;
            got_byte_reg <= got_byte_next;
            rbyte_reg    <= rbyte_next;

            if (state_next != state_reg) begin
                wd_count_reg <= 16'h0000;
            end else if (wd_counting) begin
                wd_count_reg <= wd_count_reg + 16'h0001;
            end

            req_ready  <= (state_next == IDLE);
            rsp_valid  <= (state_next == RESP);
            rsp_status <= status_next;
            rsp_rdata  <= rdata_next;

            instr_converter_en <= cmd_active_next;
            instruction        <= cmd_active_next ? (write_sel ? OP_STS : OP_LDS) : 3'b000;
            size_a             <= cmd_active_next ? 2'b01 : 2'b00;

            pay0_reg       <= cmd_active_next ? addr_sel[7:0]  : 8'h00;
            pay1_reg       <= cmd_active_next ? addr_sel[15:8] : 8'h00;
            pay2_reg       <= (cmd_active_next && write_sel) ? wdata_sel : 8'h00;
            data_len       <= cmd_active_next ?
                              (write_sel ? (DATA_ADDR_BITS+1)'(3) : (DATA_ADDR_BITS+1)'(2)) : '0;
            wait_ack_after <= (cmd_active_next && write_sel) ? WRITE_ACK_MASK : '0;

            // Start levels are high exactly while their start state lasts.
            tx_start   <= (state_next == TX_START);
            rx_start   <= (state_next == RX_START);
            rx_n_bytes <= ((state_next == RX_START) || (state_next == RX_WAIT)) ?
                          DATA_ADDR_BITS'(1) : '0;
        end
    end

endmodule
